// File: rtl/vpg_mode_sequencer_if.sv
// Mode-request handshake between the requester (master) and the mode sequencer (slave).
interface vpg_mode_sequencer_if;
  logic [3:0] mode_req;
  logic       mode_req_valid;
  logic       mode_req_ready;

  modport master (output mode_req, output mode_req_valid, input  mode_req_ready);
  modport slave  (input  mode_req, input  mode_req_valid, output mode_req_ready);
endinterface

// File: rtl/vpg_mode_sequencer.sv
// Video mode switch sequencer: applies a requested mode and strobes the PLL reconfiguration.
// It then holds the timing generator in reset until the pixel PLL has relocked and settled.
module vpg_mode_sequencer #(
  parameter logic [3:0]  DEFAULT_MODE = 4'd0,
  parameter int unsigned UNLOCK_TO    = 1024,
  parameter int unsigned LOCK_TO      = 500000,
  parameter int unsigned SETTLE_CYC   = 65536,
  parameter int unsigned CNT_W        = 20
) (
  input  logic                       clk_50,
  input  logic                       reset_n,
  vpg_mode_sequencer_if.slave        req_if,
  input  logic                       gen_clk_locked,
  output logic [3:0]                 mode,
  output logic                       mode_change,
  output logic                       gen_reset_n,
  output logic                       blank,
  output logic                       busy,
  output logic                       error
);

  localparam logic [2:0] S_RUN         = 3'd0;
  localparam logic [2:0] S_APPLY       = 3'd1;
  localparam logic [2:0] S_WAIT_UNLOCK = 3'd2;
  localparam logic [2:0] S_WAIT_LOCK   = 3'd3;
  localparam logic [2:0] S_SETTLE      = 3'd4;
  localparam logic [2:0] S_ERROR       = 3'd5;

  localparam logic [CNT_W-1:0] UNLOCK_LIM = CNT_W'(UNLOCK_TO - 1);
  localparam logic [CNT_W-1:0] LOCK_LIM   = CNT_W'(LOCK_TO - 1);
  localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYC - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lk_meta;
  logic             r_lk_s;
  logic [3:0]       r_mode;
  logic             r_mode_change;
  logic             r_gen_reset_n;
  logic             r_blank;
  logic             r_busy;
  logic             r_error;
  logic             r_ready;
  logic             w_accept;
  logic             w_load_mode;
  logic             w_waiting;

  assign w_accept  = req_if.mode_req_valid & r_ready;
  assign w_waiting = (r_state == S_WAIT_UNLOCK) || (r_state == S_WAIT_LOCK) || (r_state == S_SETTLE);

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_lk_meta <= 1'b0;
      r_lk_s    <= 1'b0;
    end else begin
      r_lk_meta <= gen_clk_locked;
      r_lk_s    <= r_lk_meta;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_load_mode = 1'b0;
    case (r_state)
      S_RUN: begin
        // A differing request wins over a simultaneous lock loss: the switch relocks anyway.
        if (w_accept && (req_if.mode_req != r_mode)) begin
          w_next      = S_APPLY;
          w_load_mode = 1'b1;
        end else if (!r_lk_s) begin
          w_next = S_WAIT_LOCK;
        end
      end
      S_APPLY:       w_next = S_WAIT_UNLOCK;
      S_WAIT_UNLOCK: if (!r_lk_s || (r_cnt == UNLOCK_LIM)) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (r_lk_s)                 w_next = S_SETTLE;
        else if (r_cnt == LOCK_LIM) w_next = S_ERROR;
      end
      S_SETTLE: begin
        if (!r_lk_s)                  w_next = S_WAIT_LOCK;
        else if (r_cnt == SETTLE_LIM) w_next = S_RUN;
      end
      S_ERROR: begin
        if (w_accept) begin
          w_next      = S_APPLY;
          w_load_mode = 1'b1;
        end else if (r_lk_s) begin
          w_next = S_SETTLE;
        end
      end
      default: w_next = S_WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so they change on the transition edge itself.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_WAIT_LOCK;
      r_cnt         <= '0;
      r_mode        <= DEFAULT_MODE;
      r_mode_change <= 1'b0;
      r_gen_reset_n <= 1'b0;
      r_blank       <= 1'b1;
      r_busy        <= 1'b1;
      r_error       <= 1'b0;
      r_ready       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_waiting)    r_cnt <= r_cnt + 1'b1;
      if (w_load_mode) r_mode <= req_if.mode_req;
      r_mode_change <= (w_next == S_APPLY);
      r_gen_reset_n <= (w_next == S_RUN);
      r_blank       <= (w_next != S_RUN);
      r_busy        <= (w_next != S_RUN) && (w_next != S_ERROR);
      r_ready       <= (w_next == S_RUN) || (w_next == S_ERROR);
      r_error       <= (w_next == S_ERROR) || (r_error && !w_accept);
    end
  end

  assign req_if.mode_req_ready = r_ready;
  assign mode        = r_mode;
  assign mode_change = r_mode_change;
  assign gen_reset_n = r_gen_reset_n;
  assign blank       = r_blank;
  assign busy        = r_busy;
  assign error       = r_error;

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Bench for vpg_mode_sequencer with short timeouts; mode strobes are checked against a queue of expected modes.
module tb_vpg_mode_sequencer;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked;
  logic [3:0] mode;
  logic       mode_change, gen_reset_n, blank, busy, error;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         strobe_cnt = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;

  vpg_mode_sequencer_if req_if();

  vpg_mode_sequencer #(
    .DEFAULT_MODE(4'd0), .UNLOCK_TO(8), .LOCK_TO(32), .SETTLE_CYC(16), .CNT_W(8)
  ) dut (
    .clk_50(clk), .reset_n(reset_n), .req_if(req_if), .gen_clk_locked(locked),
    .mode(mode), .mode_change(mode_change), .gen_reset_n(gen_reset_n),
    .blank(blank), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && mode_change === 1'b1) begin
      strobe_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got strobe with mode %0d, want no strobe", mode);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mode !== mon_exp) begin
          n_fail++;
          $display("FAIL strobe_mode: got %0d want %0d", mode, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [3:0] code, input bit expect_strobe);
    req_if.mode_req       = code;
    req_if.mode_req_valid = 1'b1;
    if (expect_strobe) exp_q.push_back(code);
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if ({mode, mode_change, gen_reset_n, blank, busy, error, req_if.mode_req_ready} !== {4'd0, 6'b001100}) begin
      n_fail++;
      $display("FAIL %s: got mode=%0d chg=%b grn=%b blank=%b busy=%b err=%b rdy=%b want 0 0 0 1 1 0 0",
               tag, mode, mode_change, gen_reset_n, blank, busy, error, req_if.mode_req_ready);
    end
  endtask

  task automatic wait_run(input int max_c, output int run_at);
    run_at = 0;
    for (int c = 1; c <= max_c && run_at == 0; c++) begin
      tick();
      if (gen_reset_n === 1'b1) run_at = c;
    end
  endtask

  task automatic test_reset();
    int run_at;
    reset_n = 1'b0; locked = 1'b1;
    req_if.mode_req = 4'd0; req_if.mode_req_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    check_reset_values("reset_values");
    wait_run(30, run_at);
    n_tests++;
    if (run_at != 19) begin n_fail++; $display("FAIL powerup_run_cycle: got %0d want 19", run_at); end
    n_tests++;
    if ({blank, busy, req_if.mode_req_ready, mode} !== {3'b001, 4'd0}) begin
      n_fail++;
      $display("FAIL powerup_run_outputs: got blank=%b busy=%b rdy=%b mode=%0d want 0 0 1 0",
               blank, busy, req_if.mode_req_ready, mode);
    end
  endtask

  task automatic test_normal_switch();
    int run_at = 0;
    int ready_hi = 0;
    int s0 = strobe_cnt;
    request(4'd2, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        req_if.mode_req_valid = 1'b0;
        n_tests++;
        if ({mode, mode_change, blank} !== {4'd2, 2'b11}) begin
          n_fail++;
          $display("FAIL switch_accept: got mode=%0d chg=%b blank=%b want 2 1 1", mode, mode_change, blank);
        end
      end
      if (c == 4)  locked = 1'b0;
      if (c == 14) locked = 1'b1;
      if (run_at == 0 && gen_reset_n === 1'b1) run_at = c;
      if (run_at == 0 && req_if.mode_req_ready !== 1'b0) ready_hi++;
    end
    n_tests++;
    if (run_at != 33) begin n_fail++; $display("FAIL switch_run_cycle: got %0d want 33", run_at); end
    n_tests++;
    if (ready_hi != 0) begin n_fail++; $display("FAIL switch_backpressure: got %0d ready cycles want 0", ready_hi); end
    n_tests++;
    if (strobe_cnt - s0 != 1) begin n_fail++; $display("FAIL switch_strobes: got %0d want 1", strobe_cnt - s0); end
    n_tests++;
    if ({error, blank, mode} !== {2'b00, 4'd2}) begin
      n_fail++;
      $display("FAIL switch_final: got err=%b blank=%b mode=%0d want 0 0 2", error, blank, mode);
    end
  endtask

  task automatic test_no_unlock();
    int run_at;
    request(4'd5, 1'b1);
    tick();
    req_if.mode_req_valid = 1'b0;
    wait_run(40, run_at);
    n_tests++;
    if (run_at + 1 != 27) begin n_fail++; $display("FAIL nounlock_run_cycle: got %0d want 27", run_at + 1); end
  endtask

  task automatic test_relock_timeout();
    int run_at;
    request(4'd3, 1'b1);
    locked = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (c == 1) req_if.mode_req_valid = 1'b0;
      if (c == 34) begin
        n_tests++;
        if ({error, busy} !== 2'b01) begin
          n_fail++; $display("FAIL relock_before_to: got err=%b busy=%b want 0 1", error, busy);
        end
      end
    end
    n_tests++;
    if ({error, blank, req_if.mode_req_ready, busy, gen_reset_n} !== 5'b11100) begin
      n_fail++;
      $display("FAIL relock_error_state: got err=%b blank=%b rdy=%b busy=%b grn=%b want 1 1 1 0 0",
               error, blank, req_if.mode_req_ready, busy, gen_reset_n);
    end
    request(4'd2, 1'b1);
    tick();
    req_if.mode_req_valid = 1'b0;
    locked = 1'b1;
    n_tests++;
    if ({error, mode, mode_change, req_if.mode_req_ready} !== {1'b0, 4'd2, 2'b10}) begin
      n_fail++;
      $display("FAIL retry_accept: got err=%b mode=%0d chg=%b rdy=%b want 0 2 1 0",
               error, mode, mode_change, req_if.mode_req_ready);
    end
    wait_run(40, run_at);
    n_tests++;
    if (run_at + 1 != 20) begin n_fail++; $display("FAIL retry_run_cycle: got %0d want 20", run_at + 1); end
  endtask

  task automatic test_settle_glitch();
    int run_at = 0;
    request(4'd7, 1'b1);
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 1)  req_if.mode_req_valid = 1'b0;
      if (c == 21) locked = 1'b0;
      if (c == 22) locked = 1'b1;
      if (run_at == 0 && gen_reset_n === 1'b1) run_at = c;
    end
    n_tests++;
    if (run_at != 41) begin n_fail++; $display("FAIL glitch_run_cycle: got %0d want 41", run_at); end
  endtask

  task automatic test_same_mode();
    int s0 = strobe_cnt;
    int blank_hi = 0;
    request(4'd7, 1'b0);
    tick();
    req_if.mode_req_valid = 1'b0;
    n_tests++;
    if ({mode, gen_reset_n, busy, req_if.mode_req_ready} !== {4'd7, 3'b101}) begin
      n_fail++;
      $display("FAIL same_accept: got mode=%0d grn=%b busy=%b rdy=%b want 7 1 0 1",
               mode, gen_reset_n, busy, req_if.mode_req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      if (blank !== 1'b0) blank_hi++;
      tick();
    end
    n_tests++;
    if (blank_hi != 0 || strobe_cnt != s0) begin
      n_fail++;
      $display("FAIL same_no_switch: got blank_cycles=%0d strobes=%0d want 0 0", blank_hi, strobe_cnt - s0);
    end
  endtask

  task automatic test_mid_reset();
    int run_at;
    request(4'd1, 1'b1);
    locked = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) req_if.mode_req_valid = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset_values");
    locked = 1'b1;
    #2;
    reset_n = 1'b1;
    wait_run(30, run_at);
    n_tests++;
    if (run_at != 19 || mode !== 4'd0) begin
      n_fail++;
      $display("FAIL midreset_recover: got run=%0d mode=%0d want 19 0", run_at, mode);
    end
  endtask

  initial begin
    test_reset();
    test_normal_switch();
    test_no_unlock();
    test_relock_timeout();
    test_settle_glitch();
    test_same_mode();
    test_mid_reset();
    repeat (2) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL strobes_missing: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
